// File: rtl/axi_bus_arbiter.sv
// Round-robin arbiter sharing one AXI4 master port between the IFU (read-only)
// and the LSU (read/write), issuing one single-beat transaction at a time.
module axi_bus_arbiter #(
    parameter int ADDR_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  rst_n,

    input  logic                  m0_req,
    input  logic [ADDR_WIDTH-1:0] m0_addr,
    output logic                  m0_ready,
    output logic                  m0_rvalid,
    output logic [31:0]           m0_rdata,
    output logic                  m0_err,

    input  logic                  m1_req,
    input  logic                  m1_wr,
    input  logic [ADDR_WIDTH-1:0] m1_addr,
    input  logic [31:0]           m1_wdata,
    input  logic [3:0]            m1_wstrb,
    output logic                  m1_ready,
    output logic                  m1_done,
    output logic [31:0]           m1_rdata,
    output logic                  m1_err,

    output logic [ADDR_WIDTH-1:0] awaddr,
    output logic                  awvalid,
    input  logic                  awready,
    output logic [7:0]            awlen,
    output logic [2:0]            awsize,
    output logic [1:0]            awburst,

    output logic [31:0]           wdata,
    output logic [3:0]            wstrb,
    output logic                  wvalid,
    output logic                  wlast,
    input  logic                  wready,

    input  logic [1:0]            bresp,
    input  logic                  bvalid,
    output logic                  bready,

    output logic [ADDR_WIDTH-1:0] araddr,
    output logic                  arvalid,
    input  logic                  arready,
    output logic [7:0]            arlen,
    output logic [2:0]            arsize,
    output logic [1:0]            arburst,

    input  logic [31:0]           rdata,
    input  logic [1:0]            rresp,
    input  logic                  rlast,
    input  logic                  rvalid,
    output logic                  rready
);

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        RD_ADDR = 3'd1,
        RD_DATA = 3'd2,
        WR_ADDR = 3'd3,
        WR_RESP = 3'd4
    } state_t;

    state_t                  state_q, state_d;
    logic                    last_grant_q, last_grant_d;
    logic                    owner_q, owner_d;
    logic [ADDR_WIDTH-1:0]   addr_q, addr_d;
    logic [31:0]             wdata_q, wdata_d;
    logic [3:0]              wstrb_q, wstrb_d;
    logic                    aw_done_q, aw_done_d;
    logic                    w_done_q, w_done_d;
    logic                    m0_rvalid_q, m0_rvalid_d;
    logic                    m1_done_q, m1_done_d;
    logic [31:0]             m0_rdata_q, m0_rdata_d;
    logic [31:0]             m1_rdata_q, m1_rdata_d;
    logic                    m0_err_q, m0_err_d;
    logic                    m1_err_q, m1_err_d;

    logic                    grant0, grant1;
    logic                    aw_ok, w_ok;
    logic                    unused_resp_bits;

    // On conflict, the port that did not win last time gets the bus
    assign grant1 = m1_req && (!m0_req || !last_grant_q);
    assign grant0 = m0_req && (!m1_req ||  last_grant_q);

    assign unused_resp_bits = ^{rresp[0], bresp[0]};

    assign awlen   = 8'd0;
    assign arlen   = 8'd0;
    assign awsize  = 3'b010;
    assign arsize  = 3'b010;
    assign awburst = 2'b01;
    assign arburst = 2'b01;
    assign awaddr  = addr_q;
    assign araddr  = addr_q;
    assign wdata   = wdata_q;
    assign wstrb   = wstrb_q;
    assign wlast   = wvalid;

    assign m0_rvalid = m0_rvalid_q;
    assign m0_rdata  = m0_rdata_q;
    assign m0_err    = m0_err_q;
    assign m1_done   = m1_done_q;
    assign m1_rdata  = m1_rdata_q;
    assign m1_err    = m1_err_q;

    always_comb begin
        state_d      = state_q;
        last_grant_d = last_grant_q;
        owner_d      = owner_q;
        addr_d       = addr_q;
        wdata_d      = wdata_q;
        wstrb_d      = wstrb_q;
        aw_done_d    = aw_done_q;
        w_done_d     = w_done_q;
        m0_rvalid_d  = 1'b0;
        m1_done_d    = 1'b0;
        m0_rdata_d   = m0_rdata_q;
        m1_rdata_d   = m1_rdata_q;
        m0_err_d     = m0_err_q;
        m1_err_d     = m1_err_q;
        m0_ready     = 1'b0;
        m1_ready     = 1'b0;
        arvalid      = 1'b0;
        rready       = 1'b0;
        awvalid      = 1'b0;
        wvalid       = 1'b0;
        bready       = 1'b0;
        aw_ok        = 1'b0;
        w_ok         = 1'b0;

        case (state_q)
            IDLE: begin
                if (grant1) begin
                    m1_ready     = 1'b1;
                    owner_d      = 1'b1;
                    last_grant_d = 1'b1;
                    addr_d       = m1_addr;
                    wdata_d      = m1_wdata;
                    wstrb_d      = m1_wstrb;
                    aw_done_d    = 1'b0;
                    w_done_d     = 1'b0;
                    state_d      = m1_wr ? WR_ADDR : RD_ADDR;
                end else if (grant0) begin
                    m0_ready     = 1'b1;
                    owner_d      = 1'b0;
                    last_grant_d = 1'b0;
                    addr_d       = m0_addr;
                    state_d      = RD_ADDR;
                end
            end
            RD_ADDR: begin
                arvalid = 1'b1;
                if (arready) state_d = RD_DATA;
            end
            RD_DATA: begin
                rready = 1'b1;
                // Only the last beat completes; stray earlier beats are dropped
                if (rvalid && rlast) begin
                    if (owner_q) begin
                        m1_rdata_d = rdata;
                        m1_err_d   = rresp[1];
                        m1_done_d  = 1'b1;
                    end else begin
                        m0_rdata_d  = rdata;
                        m0_err_d    = rresp[1];
                        m0_rvalid_d = 1'b1;
                    end
                    state_d = IDLE;
                end
            end
            WR_ADDR: begin
                awvalid   = !aw_done_q;
                wvalid    = !w_done_q;
                aw_ok     = aw_done_q || awready;
                w_ok      = w_done_q  || wready;
                aw_done_d = aw_ok;
                w_done_d  = w_ok;
                if (aw_ok && w_ok) state_d = WR_RESP;
            end
            WR_RESP: begin
                bready = 1'b1;
                if (bvalid) begin
                    m1_err_d  = bresp[1];
                    m1_done_d = 1'b1;
                    state_d   = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            last_grant_q <= 1'b0;
            owner_q      <= 1'b0;
            addr_q       <= '0;
            wdata_q      <= '0;
            wstrb_q      <= '0;
            aw_done_q    <= 1'b0;
            w_done_q     <= 1'b0;
            m0_rvalid_q  <= 1'b0;
            m1_done_q    <= 1'b0;
            m0_rdata_q   <= '0;
            m1_rdata_q   <= '0;
            m0_err_q     <= 1'b0;
            m1_err_q     <= 1'b0;
        end else begin
            state_q      <= state_d;
            last_grant_q <= last_grant_d;
            owner_q      <= owner_d;
            addr_q       <= addr_d;
            wdata_q      <= wdata_d;
            wstrb_q      <= wstrb_d;
            aw_done_q    <= aw_done_d;
            w_done_q     <= w_done_d;
            m0_rvalid_q  <= m0_rvalid_d;
            m1_done_q    <= m1_done_d;
            m0_rdata_q   <= m0_rdata_d;
            m1_rdata_q   <= m1_rdata_d;
            m0_err_q     <= m0_err_d;
            m1_err_q     <= m1_err_d;
        end
    end

endmodule

// File: tb/tb_axi_bus_arbiter.sv
// Directed bench for axi_bus_arbiter: inputs change on the falling edge,
// outputs are checked 1 time unit later.
module tb_axi_bus_arbiter;

    localparam int AW = 32;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          m0_req;
    logic [AW-1:0] m0_addr;
    logic          m0_ready, m0_rvalid, m0_err;
    logic [31:0]   m0_rdata;
    logic          m1_req, m1_wr;
    logic [AW-1:0] m1_addr;
    logic [31:0]   m1_wdata;
    logic [3:0]    m1_wstrb;
    logic          m1_ready, m1_done, m1_err;
    logic [31:0]   m1_rdata;
    logic [AW-1:0] awaddr, araddr;
    logic          awvalid, awready, wvalid, wlast, wready, bvalid, bready;
    logic          arvalid, arready, rlast, rvalid, rready;
    logic [7:0]    awlen, arlen;
    logic [2:0]    awsize, arsize;
    logic [1:0]    awburst, arburst, bresp, rresp;
    logic [31:0]   wdata, rdata;
    logic [3:0]    wstrb;

    int checks = 0;
    int errors = 0;
    int grants[$];

    always #5 clk = ~clk;

    axi_bus_arbiter #(.ADDR_WIDTH(AW)) dut (
        .clk(clk), .rst_n(rst_n),
        .m0_req(m0_req), .m0_addr(m0_addr), .m0_ready(m0_ready),
        .m0_rvalid(m0_rvalid), .m0_rdata(m0_rdata), .m0_err(m0_err),
        .m1_req(m1_req), .m1_wr(m1_wr), .m1_addr(m1_addr),
        .m1_wdata(m1_wdata), .m1_wstrb(m1_wstrb), .m1_ready(m1_ready),
        .m1_done(m1_done), .m1_rdata(m1_rdata), .m1_err(m1_err),
        .awaddr(awaddr), .awvalid(awvalid), .awready(awready),
        .awlen(awlen), .awsize(awsize), .awburst(awburst),
        .wdata(wdata), .wstrb(wstrb), .wvalid(wvalid), .wlast(wlast),
        .wready(wready),
        .bresp(bresp), .bvalid(bvalid), .bready(bready),
        .araddr(araddr), .arvalid(arvalid), .arready(arready),
        .arlen(arlen), .arsize(arsize), .arburst(arburst),
        .rdata(rdata), .rresp(rresp), .rlast(rlast), .rvalid(rvalid),
        .rready(rready)
    );

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic clear_inputs();
        m0_req = 0; m0_addr = '0;
        m1_req = 0; m1_wr = 0; m1_addr = '0; m1_wdata = '0; m1_wstrb = '0;
        awready = 0; wready = 0; bvalid = 0; bresp = '0;
        arready = 0; rvalid = 0; rlast = 0; rdata = '0; rresp = '0;
    endtask

    task automatic do_reset();
        rst_n = 0;
        repeat (2) @(negedge clk);
        rst_n = 1;
    endtask

    initial begin
        clear_inputs();
        do_reset();

        // Reset state
        #1;
        check_eq("rst_arvalid", arvalid, 0);
        check_eq("rst_awvalid", awvalid, 0);
        check_eq("rst_wvalid", wvalid, 0);
        check_eq("rst_rready", rready, 0);
        check_eq("rst_bready", bready, 0);
        check_eq("rst_m0_rvalid", m0_rvalid, 0);
        check_eq("rst_m1_done", m1_done, 0);
        check_eq("rst_m0_rdata", m0_rdata, 0);
        check_eq("rst_araddr", araddr, 0);
        check_eq("const_arsize", arsize, 3'b010);
        check_eq("const_awburst", awburst, 2'b01);
        check_eq("const_arlen", arlen, 0);

        // IFU-only read with immediate arready
        @(negedge clk);
        m0_req = 1; m0_addr = 32'h100; arready = 1;
        rvalid = 1; rlast = 1; rdata = 32'hDEADBEEF; rresp = 2'b00;
        #1;
        check_eq("t1_m0_ready", m0_ready, 1);
        check_eq("t1_m1_ready", m1_ready, 0);
        @(negedge clk);
        m0_req = 0; m0_addr = '0;
        #1;
        check_eq("t1_arvalid", arvalid, 1);
        check_eq("t1_araddr", araddr, 32'h100);
        check_eq("t1_rready_early", rready, 0);
        @(negedge clk); #1;
        check_eq("t1_rready", rready, 1);
        check_eq("t1_arvalid_off", arvalid, 0);
        @(negedge clk);
        clear_inputs();
        #1;
        check_eq("t1_m0_rvalid", m0_rvalid, 1);
        check_eq("t1_m0_rdata", m0_rdata, 32'hDEADBEEF);
        check_eq("t1_m0_err", m0_err, 0);
        @(negedge clk); #1;
        check_eq("t1_m0_rvalid_pulse", m0_rvalid, 0);
        check_eq("t1_m0_rdata_hold", m0_rdata, 32'hDEADBEEF);

        // LSU write, wready three cycles ahead of awready, error response
        @(negedge clk);
        m1_req = 1; m1_wr = 1; m1_addr = 32'h200; m1_wdata = 32'h12345678; m1_wstrb = 4'hF;
        #1;
        check_eq("t2_m1_ready", m1_ready, 1);
        @(negedge clk);
        m1_req = 0; m1_wr = 0; m1_addr = '0; m1_wdata = '0; m1_wstrb = '0;
        wready = 1;
        #1;
        check_eq("t2_awvalid", awvalid, 1);
        check_eq("t2_wvalid", wvalid, 1);
        check_eq("t2_wlast", wlast, 1);
        check_eq("t2_awaddr", awaddr, 32'h200);
        check_eq("t2_wdata", wdata, 32'h12345678);
        check_eq("t2_wstrb", wstrb, 4'hF);
        @(negedge clk);
        wready = 0;
        #1;
        check_eq("t2_wvalid_drop", wvalid, 0);
        check_eq("t2_awvalid_hold1", awvalid, 1);
        @(negedge clk); #1;
        check_eq("t2_awvalid_hold2", awvalid, 1);
        check_eq("t2_bready_early", bready, 0);
        @(negedge clk);
        awready = 1;
        #1;
        check_eq("t2_awvalid_hold3", awvalid, 1);
        @(negedge clk);
        awready = 0; bvalid = 1; bresp = 2'b10;
        #1;
        check_eq("t2_awvalid_off", awvalid, 0);
        check_eq("t2_bready", bready, 1);
        check_eq("t2_m1_done_early", m1_done, 0);
        @(negedge clk);
        bvalid = 0; bresp = '0;
        #1;
        check_eq("t2_m1_done", m1_done, 1);
        check_eq("t2_m1_err", m1_err, 1);
        check_eq("t2_bready_off", bready, 0);
        @(negedge clk); #1;
        check_eq("t2_m1_done_pulse", m1_done, 0);

        // Both ports request continuously from reset: grants must alternate
        clear_inputs();
        m0_req = 1; m0_addr = 32'h1000;
        m1_req = 1; m1_wr = 1; m1_addr = 32'h2000; m1_wdata = 32'h55AA55AA; m1_wstrb = 4'h3;
        arready = 1; rvalid = 1; rlast = 1; rdata = 32'h0BADF00D;
        awready = 1; wready = 1; bvalid = 1;
        do_reset();
        for (int c = 0; c < 20; c++) begin
            #1;
            check_eq("t3_no_dual_ready", m0_ready & m1_ready, 0);
            if (m0_ready) grants.push_back(0);
            if (m1_ready) grants.push_back(1);
            @(negedge clk);
        end
        check_eq("t3_grant_count", (grants.size() >= 4) ? 1 : 0, 1);
        for (int i = 0; i < 4; i++)
            check_eq($sformatf("t3_grant%0d", i),
                     (i < grants.size()) ? grants[i] : 32'hFF,
                     (i % 2 == 0) ? 1 : 0);
        for (int i = 1; i < grants.size(); i++)
            check_eq($sformatf("t3_alternate%0d", i), (grants[i] != grants[i-1]) ? 1 : 0, 1);

        // Read with a non-last beat before the last beat
        clear_inputs();
        do_reset();
        m0_req = 1; m0_addr = 32'h300; arready = 1;
        #1;
        check_eq("t4_m0_ready", m0_ready, 1);
        @(negedge clk);
        m0_req = 0; m0_addr = '0;
        #1;
        check_eq("t4_arvalid", arvalid, 1);
        @(negedge clk);
        arready = 0; rvalid = 1; rlast = 0; rdata = 32'h11111111;
        #1;
        check_eq("t4_rready1", rready, 1);
        @(negedge clk);
        rlast = 1; rdata = 32'h22222222;
        #1;
        check_eq("t4_no_early_rvalid", m0_rvalid, 0);
        check_eq("t4_rready2", rready, 1);
        @(negedge clk);
        clear_inputs();
        #1;
        check_eq("t4_m0_rvalid", m0_rvalid, 1);
        check_eq("t4_m0_rdata", m0_rdata, 32'h22222222);
        @(negedge clk); #1;
        check_eq("t4_single_pulse", m0_rvalid, 0);

        // arready held low for 10 cycles on an LSU read
        @(negedge clk);
        m1_req = 1; m1_wr = 0; m1_addr = 32'h400;
        #1;
        check_eq("t5_m1_ready", m1_ready, 1);
        @(negedge clk);
        m1_addr = 32'h404; m0_req = 1; m0_addr = 32'h500;
        for (int c = 0; c < 10; c++) begin
            #1;
            check_eq("t5_arvalid", arvalid, 1);
            check_eq("t5_araddr", araddr, 32'h400);
            check_eq("t5_no_m0_ready", m0_ready, 0);
            check_eq("t5_no_m1_ready", m1_ready, 0);
            @(negedge clk);
        end
        clear_inputs();
        arready = 1;
        #1;
        check_eq("t5_arvalid_last", arvalid, 1);
        @(negedge clk);
        arready = 0; rvalid = 1; rlast = 1; rdata = 32'hCAFEF00D; rresp = 2'b10;
        #1;
        check_eq("t5_rready", rready, 1);
        @(negedge clk);
        clear_inputs();
        #1;
        check_eq("t5_m1_done", m1_done, 1);
        check_eq("t5_m1_rdata", m1_rdata, 32'hCAFEF00D);
        check_eq("t5_m1_err", m1_err, 1);
        check_eq("t5_m0_rvalid", m0_rvalid, 0);

        // Reset during WR_RESP, then a fresh LSU read
        @(negedge clk);
        m1_req = 1; m1_wr = 1; m1_addr = 32'h600; m1_wdata = 32'h77777777; m1_wstrb = 4'h1;
        #1;
        check_eq("t6_m1_ready", m1_ready, 1);
        @(negedge clk);
        clear_inputs();
        awready = 1; wready = 1;
        @(negedge clk);
        clear_inputs();
        #1;
        check_eq("t6_bready", bready, 1);
        rst_n = 0; bvalid = 1; bresp = 2'b10;
        @(negedge clk);
        rst_n = 1; bvalid = 0; bresp = '0;
        #1;
        check_eq("t6_no_done", m1_done, 0);
        check_eq("t6_bready_off", bready, 0);
        check_eq("t6_m1_err", m1_err, 0);
        check_eq("t6_m1_rdata", m1_rdata, 0);
        check_eq("t6_awaddr", awaddr, 0);
        @(negedge clk); #1;
        check_eq("t6_still_no_done", m1_done, 0);
        @(negedge clk);
        m1_req = 1; m1_wr = 0; m1_addr = 32'h700; arready = 1;
        #1;
        check_eq("t6_read_ready", m1_ready, 1);
        @(negedge clk);
        m1_req = 0; m1_addr = '0;
        #1;
        check_eq("t6_araddr", araddr, 32'h700);
        @(negedge clk);
        arready = 0; rvalid = 1; rlast = 1; rdata = 32'hA5A5A5A5;
        @(negedge clk);
        clear_inputs();
        #1;
        check_eq("t6_read_done", m1_done, 1);
        check_eq("t6_read_rdata", m1_rdata, 32'hA5A5A5A5);
        check_eq("t6_read_err", m1_err, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/axi_bus_arbiter.md
# axi_bus_arbiter

Shares the core's single AXI4 master port between the instruction fetch unit (port 0, read-only) and the load/store unit (port 1, read/write). It arbitrates round-robin between the two requesters, then sequences one single-beat AXI transaction at a time: address, data, response, completion pulse to the owner. It sits between the IFU/LSU and the system interconnect.

## Interface
- ADDR_WIDTH, 32, address width on all ports
- clk  input  1  clock
- rst_n  input  1  reset; one clock; reset is synchronous and active-low
- m0_req  input  1  IFU read request
- m0_addr  input  ADDR_WIDTH  IFU read address
- m0_ready  output  1  IFU request accepted this cycle
- m0_rvalid  output  1  one-cycle pulse: m0_rdata/m0_err valid
- m0_rdata  output  32  IFU read data
- m0_err  output  1  rresp[1] of completed IFU read
- m1_req, m1_wr  input  1 each  LSU request; 1 = write
- m1_addr  input  ADDR_WIDTH  LSU address
- m1_wdata  input  32; m1_wstrb  input  4  LSU write data/strobes
- m1_ready  output  1  LSU request accepted this cycle
- m1_done  output  1  one-cycle pulse: LSU read data or write response returned
- m1_rdata  output  32; m1_err  output  1  read data; rresp[1]/bresp[1]
- awaddr, awvalid, awready, awlen(8), awsize(3), awburst(2)  AXI write address
- wdata(32), wstrb(4), wvalid, wlast, wready  AXI write data
- bresp(2), bvalid, bready  AXI write response
- araddr, arvalid, arready, arlen(8), arsize(3), arburst(2)  AXI read address
- rdata(32), rresp(2), rlast, rvalid, rready  AXI read data

## Operation
- Constants: awlen=arlen=0, awsize=arsize=3'b010, awburst=arburst=2'b01; wlast = wvalid.
- FSM: IDLE, RD_ADDR, RD_DATA, WR_ADDR, WR_RESP.
- IDLE: grant chosen combinationally. One requester active → it wins. Both active → the port not granted most recently wins; `last_grant` resets to port 0, so LSU wins first conflict.
- Grant: mX_ready=1 for that cycle only (combinational, only in IDLE); addr/wdata/wstrb/owner latched. Read → RD_ADDR; LSU write → WR_ADDR.
- Requester holds req/addr/data stable until ready; may change them the cycle after.
- RD_ADDR: arvalid=1, araddr=latched. On arready → RD_DATA, arvalid=0.
- RD_DATA: rready=1. On rvalid&rlast → capture rdata into owner's rdata, err=rresp[1], pulse owner's rvalid/done next cycle, → IDLE. rvalid without rlast: beat ignored, stay.
- WR_ADDR: awvalid and wvalid both asserted on entry; each deasserts independently on its own handshake (done flags). When both complete (may be same cycle) → WR_RESP.
- WR_RESP: bready=1. On bvalid → m1_err=bresp[1], m1_done pulse, → IDLE.
- rready only in RD_DATA, bready only in WR_RESP; otherwise 0.
- m0_rdata/m1_rdata hold last value until next completion for that port.
- Requests arriving outside IDLE wait; no queueing beyond the requester's held req.

## Timing
- Reset (clk edge with rst_n=0): state IDLE, last_grant=0, all valid/ready/done/err outputs 0, awaddr/araddr/wdata/wstrb/rdata regs 0. Reset mid-transaction abandons it; no completion pulse.
- Grant cycle T: ready=1. T+1: arvalid or awvalid/wvalid=1.
- Min read latency: req at T, arready at T+1, rvalid&rlast at T+2 → done pulse at T+3, IDLE at T+3, next grant earliest T+3.
- Min write latency: grant T, aw/w accepted T+1, bvalid T+2 → m1_done at T+3.
- Valids never drop before handshake; addr/data stable while valid.

## Test plan
- IFU-only read 0x100, arready immediate, rdata=0xDEADBEEF rresp=0 → m0_ready@T, arvalid@T+1, m0_rvalid@T+3 with m0_rdata=0xDEADBEEF, m0_err=0.
- LSU write 0x200 data 0x12345678 wstrb 0xF, wready 3 cycles before awready → wvalid drops after its handshake, awvalid held until awready; bresp=2'b10 → m1_done with m1_err=1.
- Both request continuously from reset → grants alternate LSU, IFU, LSU, IFU; no port gets two consecutive grants.
- Read with rvalid beat rlast=0 then rlast=1 → only second beat completes; one m0_rvalid pulse.
- arready held low 10 cycles → arvalid/araddr stable throughout; no ready pulses to either port.
- rst_n low during WR_RESP → all outputs 0 next cycle, no m1_done; fresh LSU read afterward completes normally.
